// File: rtl/alu.sv
// Registered 8-bit ALU: arithmetic, logic, shift-right and shift-left groups.
// S[3:2] picks the group, S[1:0] the variant. Result and flags are captured on
// every rising clk edge; rst is synchronous and active-high.
// Optional feature macro: ALU_ROTATE_EN (enables rotate on shift variant 2'b10;
// when undefined that variant is a plain logical shift).
module alu (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] D,
  output logic       C_out,
  output logic       z,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       C_in,
  input  logic [3:0] S
);

  localparam logic [1:0] GrpArith = 2'b00;
  localparam logic [1:0] GrpLogic = 2'b01;
  localparam logic [1:0] GrpShr   = 2'b10;
  localparam logic [1:0] GrpShl   = 2'b11;

  localparam logic [1:0] FillZero  = 2'b00;
  localparam logic [1:0] FillCin   = 2'b01;
  localparam logic [1:0] FillRot   = 2'b10;
  localparam logic [1:0] FillArith = 2'b11;

  logic [7:0] d_q, d_d;
  logic       c_q, c_d;
  logic       z_q, z_d;

  logic [7:0] arith_y;
  logic [8:0] arith_sum;
  logic       shr_fill;
  logic       shl_fill;

  // Arithmetic second operand and 9-bit sum; C_out is the carry (no-borrow for subtract).
  always_comb begin
    arith_y = 8'h00;
    unique case (S[1:0])
      2'b00: arith_y = 8'h00;
      2'b01: arith_y = B;
      2'b10: arith_y = ~B;
      2'b11: arith_y = 8'hFF;
      default: arith_y = 8'h00;
    endcase
    arith_sum = {1'b0, A} + {1'b0, arith_y} + {8'h00, C_in};
  end

  // Fill bits for the shift groups; rotate falls back to zero fill when disabled.
  always_comb begin
    shr_fill = 1'b0;
    shl_fill = 1'b0;
    unique case (S[1:0])
      FillZero: begin
        shr_fill = 1'b0;
        shl_fill = 1'b0;
      end
      FillCin: begin
        shr_fill = C_in;
        shl_fill = C_in;
      end
      FillRot: begin
`ifdef ALU_ROTATE_EN
        shr_fill = A[0];
        shl_fill = A[7];
`else
        shr_fill = 1'b0;
        shl_fill = 1'b0;
`endif
      end
      FillArith: begin
        shr_fill = A[7];
        shl_fill = 1'b0;
      end
      default: begin
        shr_fill = 1'b0;
        shl_fill = 1'b0;
      end
    endcase
  end

  // Next-state result and flags; z derives from the same next value of D.
  always_comb begin
    d_d = 8'h00;
    c_d = 1'b0;
    unique case (S[3:2])
      GrpArith: begin
        d_d = arith_sum[7:0];
        c_d = arith_sum[8];
      end
      GrpLogic: begin
        unique case (S[1:0])
          2'b00: d_d = A & B;
          2'b01: d_d = A | B;
          2'b10: d_d = A ^ B;
          2'b11: d_d = ~A;
          default: d_d = 8'h00;
        endcase
        c_d = 1'b0;
      end
      GrpShr: begin
        d_d = {shr_fill, A[7:1]};
        c_d = A[0];
      end
      GrpShl: begin
        d_d = {A[6:0], shl_fill};
        c_d = A[7];
      end
      default: begin
        d_d = 8'h00;
        c_d = 1'b0;
      end
    endcase
    z_d = (d_d == 8'h00);
  end

  // Output registers with synchronous reset taking priority over any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 8'h00;
      c_q <= 1'b0;
      z_q <= 1'b1;
    end else begin
      d_q <= d_d;
      c_q <= c_d;
      z_q <= z_d;
    end
  end

  assign D     = d_q;
  assign C_out = c_q;
  assign z     = z_q;

endmodule

// File: tb/tb_alu.sv
// Table-driven bench for the registered ALU, plus reset and input-hold sequences.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [7:0] D;
  logic       C_out;
  logic       z;
  logic [7:0] A;
  logic [7:0] B;
  logic       C_in;
  logic [3:0] S;

  int n_checks = 0;
  int n_fail   = 0;

  alu dut (
    .clk   (clk),
    .rst   (rst),
    .D     (D),
    .C_out (C_out),
    .z     (z),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .S     (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [3:0] s;
    logic [7:0] d;
    logic       c;
    logic       zf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] d_exp, input logic c_exp,
                       input logic z_exp);
    n_checks++;
    if (D !== d_exp || C_out !== c_exp || z !== z_exp) begin
      n_fail++;
      $display("FAIL %s: got D=%02h C_out=%b z=%b, expected D=%02h C_out=%b z=%b",
               name, D, C_out, z, d_exp, c_exp, z_exp);
    end
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [3:0] s);
    A = a; B = b; C_in = cin; S = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back('{"inc",       8'd26,  8'd40, 1'b1, 4'b0000, 8'd27,  1'b0, 1'b0});
    vecs.push_back('{"and",       8'd26,  8'd40, 1'b1, 4'b0100, 8'd8,   1'b0, 1'b0});
    vecs.push_back('{"shr_log",   8'd26,  8'd40, 1'b1, 4'b1000, 8'd13,  1'b0, 1'b0});
    vecs.push_back('{"shl_log",   8'd26,  8'd40, 1'b1, 4'b1100, 8'd52,  1'b0, 1'b0});
    vecs.push_back('{"add_wrap",  8'd255, 8'd1,  1'b0, 4'b0001, 8'd0,   1'b1, 1'b1});
    vecs.push_back('{"sub_borrow",8'd26,  8'd40, 1'b1, 4'b0010, 8'd242, 1'b0, 1'b0});
    vecs.push_back('{"sub_noborr",8'd40,  8'd26, 1'b1, 4'b0010, 8'd14,  1'b1, 1'b0});
    vecs.push_back('{"dec",       8'd26,  8'd0,  1'b0, 4'b0011, 8'd25,  1'b1, 1'b0});
    vecs.push_back('{"dec_zero",  8'd0,   8'd0,  1'b0, 4'b0011, 8'd255, 1'b0, 1'b0});
    vecs.push_back('{"xfer_a",    8'd77,  8'd9,  1'b1, 4'b0011, 8'd77,  1'b1, 1'b0});
    vecs.push_back('{"or",        8'd26,  8'd40, 1'b1, 4'b0101, 8'd58,  1'b0, 1'b0});
    vecs.push_back('{"xor",       8'd26,  8'd40, 1'b1, 4'b0110, 8'd50,  1'b0, 1'b0});
    vecs.push_back('{"not",       8'd26,  8'd40, 1'b1, 4'b0111, 8'hE5,  1'b0, 1'b0});
    vecs.push_back('{"not_zero",  8'hFF,  8'd0,  1'b1, 4'b0111, 8'h00,  1'b0, 1'b1});
    vecs.push_back('{"shr_cin",   8'd26,  8'd0,  1'b1, 4'b1001, 8'h8D,  1'b0, 1'b0});
    vecs.push_back('{"shr_arith", 8'h81,  8'd0,  1'b0, 4'b1011, 8'hC0,  1'b1, 1'b0});
    vecs.push_back('{"shl_cin",   8'h81,  8'd0,  1'b1, 4'b1101, 8'h03,  1'b1, 1'b0});
    vecs.push_back('{"shl_arith", 8'h81,  8'd0,  1'b1, 4'b1111, 8'h02,  1'b1, 1'b0});
    vecs.push_back('{"shl_zero",  8'h80,  8'd0,  1'b0, 4'b1100, 8'h00,  1'b1, 1'b1});
`ifdef ALU_ROTATE_EN
    vecs.push_back('{"shr_rot",   8'h81,  8'd0,  1'b0, 4'b1010, 8'hC0,  1'b1, 1'b0});
    vecs.push_back('{"shl_rot",   8'h81,  8'd0,  1'b0, 4'b1110, 8'h03,  1'b1, 1'b0});
`else
    vecs.push_back('{"shr_rot",   8'h81,  8'd0,  1'b1, 4'b1010, 8'h40,  1'b1, 1'b0});
    vecs.push_back('{"shl_rot",   8'h81,  8'd0,  1'b1, 4'b1110, 8'h02,  1'b1, 1'b0});
`endif

    // Reset with a non-trivial operation presented.
    rst = 1'b1;
    A = 8'd255; B = 8'd255; C_in = 1'b1; S = 4'b0001;
    @(posedge clk);
    #1;
    check("reset_state", 8'h00, 1'b0, 1'b1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s);
      check(vecs[i].name, vecs[i].d, vecs[i].c, vecs[i].zf);
    end

    // Inputs changing mid-cycle must not reach the outputs before the next edge.
    apply(8'd26, 8'd40, 1'b1, 4'b0000);
    A = 8'd255; B = 8'd1; C_in = 1'b0; S = 4'b0001;
    #3;
    check("hold_between_edges", 8'd27, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("hold_next_edge", 8'd0, 1'b1, 1'b1);

    // Mid-stream reset discards the presented op; result appears one edge after rst falls.
    A = 8'd26; B = 8'd40; C_in = 1'b1; S = 4'b0101;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_midstream", 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    #2;
    check("reset_hold_after_fall", 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("post_reset_first", 8'd58, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
